// File: rtl/subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and default width.
package subtractor_pkg;

  localparam int unsigned SUB_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full-subtractor cell: d = a - b - bin, bout = borrow out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  // Pure combinational difference and borrow.
  always_comb begin
    d    = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: one bit per cycle LSB first, result published on DONE.
module serial_subtractor
  import subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = SUB_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             overflow
);

  localparam int unsigned    CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             bin_q, bin_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             ovf_q, ovf_d;

  logic             fs_d, fs_bout;
  logic             accept, last_bit;
  logic [WIDTH-1:0] res_shift;

  assign accept    = (state_q == IDLE) && start;
  assign last_bit  = (state_q == RUN) && (cnt_q == LAST);
  // New difference bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
  assign res_shift = WIDTH'({fs_d, res_q} >> 1);

  full_subtractor u_fs (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .bin  (bin_q),
    .d    (fs_d),
    .bout (fs_bout)
  );

  // FSM next-state: IDLE -> RUN on start, RUN -> DONE on last bit, DONE -> IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start)    state_d = RUN;
      RUN:     if (last_bit) state_d = DONE;
      DONE:                  state_d = IDLE;
      default:               state_d = IDLE;
    endcase
  end

  // Datapath next-state: load on accept, shift/accumulate in RUN, publish on the last bit.
  always_comb begin
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_d    = res_q;
    bin_d    = bin_q;
    cnt_d    = cnt_q;
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    ovf_d    = ovf_q;
    if (accept) begin
      a_sh_d  = a;
      b_sh_d  = b;
      res_d   = '0;
      bin_d   = 1'b0;
      cnt_d   = '0;
      a_msb_d = a[WIDTH-1];
      b_msb_d = b[WIDTH-1];
    end else if (state_q == RUN) begin
      a_sh_d = a_sh_q >> 1;
      b_sh_d = b_sh_q >> 1;
      res_d  = res_shift;
      bin_d  = fs_bout;
      cnt_d  = last_bit ? '0 : cnt_q + 1'b1;
      if (last_bit) begin
        // Outputs change only here, so diff/borrow/overflow hold through RUN.
        diff_d   = res_shift;
        borrow_d = fs_bout;
        ovf_d    = (a_msb_q != b_msb_q) && (fs_d != a_msb_q);
      end
    end
  end

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_q    <= '0;
      bin_q    <= 1'b0;
      cnt_q    <= '0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_q    <= res_d;
      bin_q    <= bin_d;
      cnt_q    <= cnt_d;
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
    end
  end

  assign ready    = (state_q == IDLE);
  assign done     = (state_q == DONE);
  assign diff     = diff_q;
  assign borrow   = borrow_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8) against an arithmetic model.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk, rst_n, start;
  logic [W-1:0] a, b;
  logic         ready, done, borrow, overflow;
  logic [W-1:0] diff;

  int n_checks = 0;
  int n_fail   = 0;

  // Last published result, used to check that outputs hold during RUN.
  logic [W-1:0] pd;
  logic         pb, po;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a        (a),
    .b        (b),
    .ready    (ready),
    .done     (done),
    .diff     (diff),
    .borrow   (borrow),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer arithmetic on unsigned and signed views.
  task automatic model(input logic [W-1:0] av, input logic [W-1:0] bv,
                       output logic [W-1:0] ed, output logic eb, output logic eo);
    int sd;
    ed = av - bv;
    eb = (int'(av) < int'(bv));
    sd = int'($signed(av)) - int'($signed(bv));
    eo = (sd > 127) || (sd < -128);
  endtask

  // One operation; called away from the edge with ready expected high.
  task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                       input bit noise, input string name);
    logic [W-1:0] ed;
    logic eb, eo;
    int lat;
    bit got;
    model(av, bv, ed, eb, eo);
    n_checks++;
    if (ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s ready_before: got %b want 1", name, ready);
    end
    start = 1'b1; a = av; b = bv;
    @(posedge clk); #1;
    start = 1'b0; a = W'($urandom); b = W'($urandom);
    lat = 0; got = 0;
    for (int i = 0; i < 20; i++) begin
      if (done === 1'b1) begin got = 1; break; end
      n_checks++;
      if ({diff, borrow, overflow, ready} !== {pd, pb, po, 1'b0}) begin
        n_fail++;
        $display("FAIL %s hold_run: got d=%h b=%b o=%b r=%b want d=%h b=%b o=%b r=0",
                 name, diff, borrow, overflow, ready, pd, pb, po);
      end
      lat++;
      if (noise) begin
        start = 1'($urandom); a = W'($urandom); b = W'($urandom);
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    n_checks++;
    if (!got || lat != W) begin
      n_fail++;
      $display("FAIL %s latency: got done=%0d after %0d edges want %0d", name, got, lat, W);
    end
    n_checks++;
    if ({diff, borrow, overflow} !== {ed, eb, eo}) begin
      n_fail++;
      $display("FAIL %s result a=%h b=%h: got d=%h b=%b o=%b want d=%h b=%b o=%b",
               name, av, bv, diff, borrow, overflow, ed, eb, eo);
    end
    @(posedge clk); #1;
    n_checks++;
    if ({done, ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL %s after_done: got done=%b ready=%b want done=0 ready=1", name, done, ready);
    end
    pd = ed; pb = eb; po = eo;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    pd = '0; pb = 1'b0; po = 1'b0;
    #3;
    n_checks++;
    if ({ready, done, diff, borrow, overflow} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state: got r=%b dn=%b d=%h b=%b o=%b want r=1 dn=0 d=00 b=0 o=0",
               ready, done, diff, borrow, overflow);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    do_op(8'h05, 8'h03, 0, "5-3");
    do_op(8'h03, 8'h05, 0, "3-5");
    do_op(8'h00, 8'h01, 0, "0-1");
    do_op(8'h80, 8'h01, 0, "80-1");
    do_op(8'h7F, 8'hFF, 0, "7f-ff");
    do_op(8'hA5, 8'hA5, 0, "a_eq_b");
    do_op(8'hC3, 8'h00, 0, "b_zero");
    do_op(8'hFF, 8'h00, 0, "ff-0");
    do_op(8'h00, 8'hFF, 0, "0-ff");
    do_op(8'h7F, 8'h80, 0, "7f-80");
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++)
      do_op(W'($urandom), W'($urandom), 1, "random_noisy");
  endtask

  task automatic test_reset_midrun();
    int seen;
    start = 1'b1; a = 8'h10; b = 8'h01;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({ready, done, diff, borrow, overflow} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL midrun_reset: got r=%b dn=%b d=%h b=%b o=%b want r=1 dn=0 d=00 b=0 o=0",
               ready, done, diff, borrow, overflow);
    end
    pd = '0; pb = 1'b0; po = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL abandoned_done: got %0d done pulses want 0", seen);
    end
    do_op(8'h10, 8'h01, 0, "after_reset");
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] qd[$];
    logic         qb[$], qo[$];
    logic [W-1:0] ed;
    logic eb, eo;
    int last_done, nacc, ndone;
    last_done = -1; nacc = 0; ndone = 0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (done === 1'b1) begin
        ndone++;
        n_checks++;
        if (qd.size() == 0) begin
          n_fail++;
          $display("FAIL b2b_spurious_done: got done at cycle %0d want none", cyc);
        end else begin
          ed = qd.pop_front(); eb = qb.pop_front(); eo = qo.pop_front();
          if ({diff, borrow, overflow} !== {ed, eb, eo}) begin
            n_fail++;
            $display("FAIL b2b_result: got d=%h b=%b o=%b want d=%h b=%b o=%b",
                     diff, borrow, overflow, ed, eb, eo);
          end
        end
        if (last_done >= 0) begin
          n_checks++;
          if (cyc - last_done != W + 2) begin
            n_fail++;
            $display("FAIL b2b_interval: got %0d want %0d", cyc - last_done, W + 2);
          end
        end
        last_done = cyc;
      end
      if (cyc < 45) begin
        start = 1'b1; a = W'($urandom); b = W'($urandom);
        if (ready === 1'b1) begin
          model(a, b, ed, eb, eo);
          qd.push_back(ed); qb.push_back(eb); qo.push_back(eo);
          nacc++;
        end
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    n_checks++;
    if (ndone != nacc || nacc < 4) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d dones for %0d accepts", ndone, nacc);
    end
    if (ndone > 0) begin
      pd = diff; pb = borrow; po = overflow;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_reset_midrun();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; legal range 2..32.
REQ-002 clk  input  1  rising-edge clock; sole clock domain.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request; a new operation is accepted on a rising edge where start=1 and ready=1.
REQ-005 a  input  WIDTH  minuend; sampled only on the accept edge.
REQ-006 b  input  WIDTH  subtrahend; sampled only on the accept edge.
REQ-007 ready  output  1  high only in state IDLE.
REQ-008 done  output  1  single-cycle pulse; result valid.
REQ-009 diff  output  WIDTH  result (a - b) mod 2^WIDTH.
REQ-010 borrow  output  1  1 when unsigned a < b.
REQ-011 overflow  output  1  1 on two's-complement signed overflow of a - b.

Function
REQ-012 Three-state FSM: IDLE, RUN, DONE; no other states.
REQ-013 Transition IDLE->RUN on start=1. In IDLE with start=0, stay in IDLE.
REQ-014 On the accept edge, latch a and b into shift registers, clear the borrow flip-flop to 0, and clear the bit counter to 0.
REQ-015 RUN: each edge processes one bit, LSB first, through the full-subtractor cell: d = a_i ^ b_i ^ bin; bout = (~a_i & b_i) | (~(a_i ^ b_i) & bin).
REQ-016 RUN: each edge shifts d into the result register from the MSB side, stores bout in the borrow flip-flop, and increments the counter.
REQ-017 RUN->DONE on the edge that processes bit WIDTH-1 (the counter reaches WIDTH-1); RUN lasts exactly WIDTH cycles.
REQ-018 DONE: done=1 for exactly one cycle. DONE->IDLE unconditionally on the next edge.
REQ-019 Latency: if the accept is edge E0, done is high in the cycle after edge E_WIDTH. ready returns high after edge E_(WIDTH+1).
REQ-020 diff, borrow and overflow are valid from the DONE cycle onward. They hold until the next accept edge, then hold through RUN at their previous values until the next DONE.
REQ-021 Result staging is internal and is not visible on diff while in RUN.
REQ-022 overflow = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), computed from the latched operands.
REQ-023 start while in RUN or DONE is ignored; it is neither queued nor does it disturb the operation in progress.
REQ-024 Back-to-back: start=1 in the first IDLE cycle after DONE is accepted. Maximum throughput is one result per WIDTH+2 cycles.
REQ-025 a == b gives diff=0, borrow=0, overflow=0. b == 0 gives diff=a, borrow=0.

Reset
REQ-026 Asserting rst_n=0 at any time, including mid-RUN, immediately forces state=IDLE, ready=1, done=0, diff=0, borrow=0, overflow=0, counter=0, and shift registers=0.
REQ-027 An operation interrupted by reset is abandoned, and no done pulse is produced for it.
REQ-028 The first accept is possible on the first rising edge after rst_n deasserts.

Structure
REQ-029 Shared package subtractor_pkg holds the FSM state encoding (IDLE, RUN, DONE) and the default WIDTH constant.
REQ-030 One sub-module, full_subtractor (a, b, bin -> d, bout), is purely combinational and is instantiated once for the per-bit cell.
REQ-031 The counter width is clog2(WIDTH) bits; all state is held in flip-flops, with no latches.

Verification (WIDTH=8)
REQ-032 a=0x05, b=0x03, start pulsed at E0 -> done after E8; diff=0x02, borrow=0, overflow=0; ready high again after E9.
REQ-033 a=0x03, b=0x05 -> diff=0xFE, borrow=1, overflow=0. Also a=0x00, b=0x01 -> diff=0xFF, borrow=1.
REQ-034 a=0x80, b=0x01 -> diff=0x7F, borrow=0, overflow=1. Also a=0x7F, b=0xFF -> diff=0x80, borrow=1, overflow=1.
REQ-035 start held high continuously with a/b changed every cycle -> only the operands sampled at each accept edge are used. Results arrive every 10 cycles, with exactly one done pulse per accept.
REQ-036 rst_n pulsed low 4 cycles after accepting a=0x10, b=0x01 -> all outputs are 0 and ready=1 immediately, no done follows. A new operation a=0x10, b=0x01 then yields diff=0x0F.
